// File: rtl/majority_window_filter.sv
// majority_window_filter: serial bit stream -> WIN-bit window with running
// ones count, registered majority decision over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   bit_in, in_valid    serial input bit and its qualifier
//   in_ready            block can take a bit this cycle
//   flush               synchronous clear of window/count/fill state
//   maj_out             decision: ones_cnt > WIN/2
//   window              window at decision time, newest bit at [0]
//   ones_cnt            popcount of window at decision time
//   out_valid/out_ready output handshake
//
// MODE 0 = sliding (one decision per bit once full)
// MODE 1 = block (one decision per non-overlapping WIN-bit group)
module majority_window_filter #(
    parameter int WIN  = 7,
    parameter int MODE = 0,
    parameter int CW   = $clog2(WIN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bit_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           flush,
    output logic           maj_out,
    output logic [WIN-1:0] window,
    output logic [CW-1:0]  ones_cnt,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam logic [CW-1:0] FULLC = CW'(WIN);
    localparam logic [CW-1:0] LASTC = CW'(WIN - 1);
    localparam logic [CW-1:0] HALF  = CW'(WIN / 2);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [WIN-1:0] sh;
    logic [WIN-1:0] sh_nxt;
    logic [CW-1:0]  fcnt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           acc;
    logic           xfer;
    logic           full;
    logic           done;

    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

    // fcnt only reaches WIN in sliding mode; block mode clears at WIN-1+1
    assign full   = (fcnt == FULLC);
    assign done   = acc & (fcnt >= LASTC);
    assign sh_nxt = {sh[WIN-2:0], bit_in};

    // Incremental popcount; when full the bit shifted out leaves the count.
    // Modular wrap of the intermediate sum is harmless at CW bits.
    always_comb begin
        cnt_nxt = cnt + CW'(bit_in);
        if (full) begin
            cnt_nxt = cnt_nxt - CW'(sh[WIN-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh        <= '0;
            fcnt      <= '0;
            cnt       <= '0;
            maj_out   <= 1'b0;
            window    <= '0;
            ones_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // output data kept; out_valid=0 marks it stale
            sh        <= '0;
            fcnt      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (acc) begin
                if ((MODE != 0) && done) begin
                    sh   <= '0;
                    cnt  <= '0;
                    fcnt <= '0;
                end else begin
                    sh  <= sh_nxt;
                    cnt <= cnt_nxt;
                    if (!full) begin
                        fcnt <= fcnt + ONE;
                    end
                end
            end
            if (done) begin
                window    <= sh_nxt;
                ones_cnt  <= cnt_nxt;
                maj_out   <= (cnt_nxt > HALF);
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_majority_window_filter.sv
// tb_majority_window_filter: sliding and block instances on shared stimulus,
// each checked against a queue-based reference model.
module tb_majority_window_filter;

    localparam int W  = 7;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        bit         v;
        bit [W-1:0] w;
        int         c;
        bit         m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic bit_in;
    logic in_valid;
    logic flush;
    logic out_ready;

    logic          s_rdy, s_maj, s_vld;
    logic [W-1:0]  s_win;
    logic [CW-1:0] s_cnt;
    logic          b_rdy, b_maj, b_vld;
    logic [W-1:0]  b_win;
    logic [CW-1:0] b_cnt;

    int   nvec = 0;
    int   nerr = 0;
    int   nacc;
    bit   last_acc;
    bit   qs[$];
    bit   qb[$];
    exp_t es;
    exp_t eb;
    logic [6:0] w119 = 7'd119;

    always #5 clk = ~clk;

    majority_window_filter #(.WIN(W), .MODE(0)) u_slide (
        .clk(clk), .rst(rst), .bit_in(bit_in), .in_valid(in_valid),
        .in_ready(s_rdy), .flush(flush), .maj_out(s_maj),
        .window(s_win), .ones_cnt(s_cnt), .out_valid(s_vld),
        .out_ready(out_ready)
    );

    majority_window_filter #(.WIN(W), .MODE(1)) u_block (
        .clk(clk), .rst(rst), .bit_in(bit_in), .in_valid(in_valid),
        .in_ready(b_rdy), .flush(flush), .maj_out(b_maj),
        .window(b_win), .ones_cnt(b_cnt), .out_valid(b_vld),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        qs.delete();
        qb.delete();
        es.v = 0; es.w = '0; es.c = 0; es.m = 0;
        eb.v = 0; eb.w = '0; eb.c = 0; eb.m = 0;
    endtask

    // Reference: queue holds accepted bits of the current window, oldest first
    task automatic mupd(input bit blk, inout bit q[$], inout exp_t e,
                        input bit b, input bit v, input bit ordy,
                        input bit fl);
        bit rdy;
        bit dec;
        rdy = !e.v || ordy;
        dec = 0;
        if (fl) begin
            q.delete();
            e.v = 0;
            return;
        end
        if (v && rdy) begin
            q.push_back(b);
            if (q.size() > W) void'(q.pop_front());
            if (q.size() == W) begin
                dec = 1;
                e.w = '0;
                e.c = 0;
                foreach (q[k]) begin
                    e.w = W'(e.w * 2 + q[k]);
                    e.c += int'(q[k]);
                end
                e.m = (e.c > W / 2);
                if (blk) q.delete();
            end
        end
        if (dec) e.v = 1;
        else if (e.v && ordy) e.v = 0;
    endtask

    task automatic chk_out();
        check("s_vld", 32'(s_vld), 32'(es.v));
        if (es.v) begin
            check("s_win", 32'(s_win), 32'(es.w));
            check("s_cnt", 32'(s_cnt), es.c);
            check("s_maj", 32'(s_maj), 32'(es.m));
        end
        check("b_vld", 32'(b_vld), 32'(eb.v));
        if (eb.v) begin
            check("b_win", 32'(b_win), 32'(eb.w));
            check("b_cnt", 32'(b_cnt), eb.c);
            check("b_maj", 32'(b_maj), 32'(eb.m));
        end
    endtask

    task automatic chk_reset();
        check("rst_s_vld", 32'(s_vld), 0);
        check("rst_s_win", 32'(s_win), 0);
        check("rst_s_cnt", 32'(s_cnt), 0);
        check("rst_s_maj", 32'(s_maj), 0);
        check("rst_s_rdy", 32'(s_rdy), 1);
        check("rst_b_vld", 32'(b_vld), 0);
        check("rst_b_win", 32'(b_win), 0);
        check("rst_b_cnt", 32'(b_cnt), 0);
        check("rst_b_maj", 32'(b_maj), 0);
        check("rst_b_rdy", 32'(b_rdy), 1);
    endtask

    // one clock: drive, check ready, update model, check outputs after edge
    task automatic step(input bit b, input bit v, input bit ordy,
                        input bit fl);
        bit_in    = b;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("s_rdy", 32'(s_rdy), 32'(!es.v || ordy));
        check("b_rdy", 32'(b_rdy), 32'(!eb.v || ordy));
        last_acc = v && (!eb.v || ordy) && !fl;
        mupd(1'b0, qs, es, b, v, ordy, fl);
        mupd(1'b1, qb, eb, b, v, ordy, fl);
        @(posedge clk);
        #1;
        chk_out();
    endtask

    task automatic feed(input logic [6:0] w);
        for (int k = 6; k >= 0; k--) step(w[k], 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // block words and first sliding windows
        feed(7'd99);
        check("b_win99", 32'(b_win), 99);
        check("b_cnt99", 32'(b_cnt), 4);
        check("b_maj99", 32'(b_maj), 1);
        check("s_win99", 32'(s_win), 99);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("s_win2", 32'(s_win), 32'(7'b1000110));
        check("s_cnt2", 32'(s_cnt), 3);
        check("s_maj2", 32'(s_maj), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("s_win3", 32'(s_win), 32'(7'b0001100));
        check("s_cnt3", 32'(s_cnt), 2);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("b_win28", 32'(b_win), 28);
        check("b_cnt28", 32'(b_cnt), 3);
        check("b_maj28", 32'(b_maj), 0);
        feed(7'd119);
        check("b_cnt119", 32'(b_cnt), 6);
        check("b_maj119", 32'(b_maj), 1);
        feed(7'd32);
        check("b_cnt32", 32'(b_cnt), 1);
        check("b_maj32", 32'(b_maj), 0);

        // flush mid-fill drops the concurrent bit
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        feed(7'd48);
        check("b_win48", 32'(b_win), 48);
        check("b_cnt48", 32'(b_cnt), 2);
        check("b_maj48", 32'(b_maj), 0);
        check("s_win48", 32'(s_win), 48);

        // backpressure then release
        repeat (5) step(1'($urandom % 2), 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'($urandom % 2), 1'b1, 1'b1, 1'b0);

        // asynchronous reset between edges
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        mreset();
        chk_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        feed(7'd75);
        check("b_win75", 32'(b_win), 75);
        check("b_cnt75", 32'(b_cnt), 4);
        check("b_maj75", 32'(b_maj), 1);
        check("s_win75", 32'(s_win), 75);

        // gapped input
        nacc = 0;
        for (int g = 0; g < 300 && nacc < 7; g++) begin
            step(w119[6-nacc], 1'($urandom_range(0, 2) != 0), 1'b1, 1'b0);
            if (last_acc) nacc++;
        end
        check("gap_bound", nacc, 7);
        check("b_wingap", 32'(b_win), 119);
        check("b_cntgap", 32'(b_cnt), 6);
        check("b_majgap", 32'(b_maj), 1);
        check("s_wingap", 32'(s_win), 119);

        // random soak
        repeat (600) begin
            step(1'($urandom % 2), 1'($urandom % 4 != 0),
                 1'($urandom % 3 != 0), 1'($urandom % 40 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
